// File: rtl/board_pkg.sv
// Shared board-level constants and types for the input conditioning path.
package board_pkg;

  // Raw board push-buttons pull low when pressed.
  localparam logic KEY_ACTIVE_LEVEL = 1'b0;

  // 10 ms of stability at 50 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

  typedef enum logic {
    IDLE,
    PENDING
  } submit_state_t;

endpackage

// File: rtl/debounce.sv
// Single-bit key conditioner: two-flop synchroniser, stability counter,
// debounced level and registered press/release pulses.
module debounce
  import board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_next
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            key_active;
  logic            differ;
  logic            flip;

  // Synchroniser, counter, level and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= {2{~KEY_ACTIVE_LEVEL}};
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n};
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Count consecutive cycles of disagreement; flip level once the run is long enough.
  always_comb begin
    key_active = (sync_q[1] == KEY_ACTIVE_LEVEL);
    differ     = key_active != level_q;
    flip       = differ && (cnt_q == CntMax);
    cnt_d      = '0;
    if (differ && !flip) begin
      cnt_d = cnt_q + 1'b1;
    end
    level_d    = level_q ^ flip;
    press_d    = flip & ~level_q;
    release_d  = flip & level_q;
    press_next = press_d;
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/key_input_ctrl.sv
// Board input conditioning: debounced keys plus a submit key that captures
// the switch value into a valid/ready handshake toward the core.
module key_input_ctrl
  import board_pkg::*;
#(
  parameter int unsigned BIT_WIDTH       = 4,
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SUBMIT_KEY      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_KEYS-1:0]  key_n,
  input  logic [BIT_WIDTH-2:0] sw,
  output logic [NUM_KEYS-1:0]  key_level,
  output logic [NUM_KEYS-1:0]  key_press,
  output logic [NUM_KEYS-1:0]  key_release,
  output logic [BIT_WIDTH-2:0] in_data,
  output logic                 in_valid,
  input  logic                 in_ready,
  output logic                 overrun
);

  logic [NUM_KEYS-1:0]  press_next;
  logic [BIT_WIDTH-2:0] sw_meta_q, sw_sync_q;
  logic [BIT_WIDTH-2:0] data_q, data_d;
  logic                 overrun_q, overrun_d;
  submit_state_t        state_q, state_d;
  logic                 submit;
  logic                 xfer;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk          (clk),
      .rst          (rst),
      .key_n        (key_n[i]),
      .level        (key_level[i]),
      .press_pulse  (key_press[i]),
      .release_pulse(key_release[i]),
      .press_next   (press_next[i])
    );
  end

  // Switch synchroniser and submit FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

  // Submit FSM next state. Uses the pre-register press so in_valid rises with key_press.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    submit    = press_next[SUBMIT_KEY];
    xfer      = (state_q == PENDING) && in_ready;
    unique case (state_q)
      IDLE: begin
        if (submit) begin
          data_d  = sw_sync_q;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (xfer && submit) begin
          data_d = sw_sync_q;
        end else if (xfer) begin
          state_d = IDLE;
        end else if (submit) begin
          // No slot free: drop the new value and remember it happened.
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_data  = data_q;
  assign in_valid = (state_q == PENDING);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed bench for key_input_ctrl with a short debounce window.
module tb_key_input_ctrl;

  localparam int unsigned BW = 4;
  localparam int unsigned NK = 4;
  localparam int unsigned DC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_n;
  logic [BW-2:0] sw;
  logic [NK-1:0] key_level, key_press, key_release;
  logic [BW-2:0] in_data;
  logic          in_valid, in_ready, overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_input_ctrl #(
    .BIT_WIDTH      (BW),
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DC),
    .SUBMIT_KEY     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .sw         (sw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .overrun    (overrun)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, 32'(key_level), 32'h0);
    check({tag, "_press"}, 32'(key_press), 32'h0);
    check({tag, "_release"}, 32'(key_release), 32'h0);
    check({tag, "_data"}, 32'(in_data), 32'h0);
    check({tag, "_valid"}, 32'(in_valid), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  initial begin
    rst      = 1'b1;
    key_n    = 4'b1111;
    sw       = 3'b000;
    in_ready = 1'b0;

    // Reset
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);
    check_all_zero("post_reset");

    // Clean press and release on key 0
    key_n[0] = 1'b0;
    tick(5);
    check("k0_level_early", 32'(key_level), 32'h0);
    tick(1);
    check("k0_level", 32'(key_level), 32'h1);
    check("k0_press", 32'(key_press), 32'h1);
    tick(1);
    check("k0_press_gone", 32'(key_press), 32'h0);
    check("k0_level_hold", 32'(key_level), 32'h1);
    key_n[0] = 1'b1;
    tick(5);
    check("k0_release_early", 32'(key_release), 32'h0);
    tick(1);
    check("k0_release", 32'(key_release), 32'h1);
    check("k0_level_low", 32'(key_level), 32'h0);
    tick(1);
    check("k0_release_gone", 32'(key_release), 32'h0);

    // Three-cycle glitch on key 1 must be rejected
    key_n[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("glitch_level", 32'(key_level), 32'h0);
    end
    key_n[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("glitch_level", 32'(key_level), 32'h0);
      check("glitch_press", 32'(key_press), 32'h0);
    end

    // Submit handshake
    sw = 3'b101;
    key_n[2] = 1'b0;
    tick(5);
    check("sub_valid_early", 32'(in_valid), 32'h0);
    tick(1);
    check("sub_press", 32'(key_press), 32'h4);
    check("sub_valid", 32'(in_valid), 32'h1);
    check("sub_data", 32'(in_data), 32'h5);
    sw = 3'b000;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("sub_hold_valid", 32'(in_valid), 32'h1);
      check("sub_hold_data", 32'(in_data), 32'h5);
    end
    in_ready = 1'b1;
    tick(1);
    in_ready = 1'b0;
    check("sub_xfer_valid", 32'(in_valid), 32'h0);
    tick(1);
    check("sub_idle_valid", 32'(in_valid), 32'h0);
    key_n[2] = 1'b1;
    tick(8);

    // Re-arm with 101, then a dropped press with 010
    sw = 3'b101;
    key_n[2] = 1'b0;
    tick(6);
    check("rearm_valid", 32'(in_valid), 32'h1);
    check("rearm_data", 32'(in_data), 32'h5);
    key_n[2] = 1'b1;
    tick(8);
    sw = 3'b010;
    key_n[2] = 1'b0;
    tick(5);
    check("ovr_early", 32'(overrun), 32'h0);
    tick(1);
    check("ovr_press", 32'(key_press), 32'h4);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_data", 32'(in_data), 32'h5);
    check("ovr_valid", 32'(in_valid), 32'h1);
    key_n[2] = 1'b1;
    tick(8);
    check("ovr_sticky", 32'(overrun), 32'h1);
    check("ovr_data_hold", 32'(in_data), 32'h5);

    // Reset while PENDING clears everything
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_pend_valid", 32'(in_valid), 32'h0);
    check("rst_pend_overrun", 32'(overrun), 32'h0);
    check("rst_pend_data", 32'(in_data), 32'h0);
    tick(2);

    // Transfer and new submit on the same edge
    sw = 3'b101;
    key_n[2] = 1'b0;
    tick(6);
    check("sim_first_valid", 32'(in_valid), 32'h1);
    key_n[2] = 1'b1;
    tick(8);
    sw = 3'b011;
    key_n[2] = 1'b0;
    tick(5);
    in_ready = 1'b1;
    tick(1);
    in_ready = 1'b0;
    check("sim_press", 32'(key_press), 32'h4);
    check("sim_valid", 32'(in_valid), 32'h1);
    check("sim_data", 32'(in_data), 32'h3);
    check("sim_overrun", 32'(overrun), 32'h0);
    tick(1);
    check("sim_valid_hold", 32'(in_valid), 32'h1);
    check("sim_data_hold", 32'(in_data), 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
